// File: rtl/keyboard_fifo.sv
// Keyboard scan-code FIFO with a memory-mapped data/status register pair.
// The CPU pops codes by reading BASE_ADDR and controls flush/overflow-clear at BASE_ADDR+1.
module keyboard_fifo #(
  parameter int          WIDTH        = 16,
  parameter int          DEPTH        = 8,
  parameter logic [15:0] BASE_ADDR    = 16'h6000,
  parameter int          DROP_ON_FULL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_code,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [15:0]      cpu_addr,
  input  logic             cpu_rd,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] kbd_out,
  output logic             kbd_irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int CW = ((WIDTH - 3) < 8) ? (WIDTH - 3) : 8;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [15:0] CTRL_ADDR = BASE_ADDR + 16'd1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;

  logic full, empty;
  logic do_flush, do_clear, do_pop, do_push, ovf_event;
  logic [7:0] count8;
  logic [WIDTH-1:0] status;

  always_comb begin
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
    key_ready = !reset && ((DROP_ON_FULL != 0) || !full);
    kbd_irq   = !empty;

    do_flush  = cpu_we && (cpu_addr == CTRL_ADDR) && cpu_wdata[0];
    do_clear  = cpu_we && (cpu_addr == CTRL_ADDR) && cpu_wdata[1];
    do_pop    = cpu_rd && (cpu_addr == BASE_ADDR) && !empty;
    // A code arriving while full is only stored if a pop frees a slot this cycle.
    do_push   = key_valid && key_ready && (!full || do_pop);
    ovf_event = key_valid && key_ready && full && !do_pop && !do_flush;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = ovf_event | (overflow_q & !do_clear);

    if (do_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_pop) head_d = head_q + AW'(1);
      if (do_push) tail_d = tail_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is unreset; the empty check on the read path hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push && !do_flush) begin
      mem_q[tail_q] <= key_code;
    end
  end

  always_comb begin
    count8              = 8'(count_q);
    status              = '0;
    status[CW-1:0]      = count8[CW-1:0];
    status[WIDTH-1]     = overflow_q;
    status[WIDTH-2]     = full;
    status[WIDTH-3]     = empty;

    kbd_out = '0;
    if (cpu_addr == BASE_ADDR) begin
      if (!empty) kbd_out = mem_q[head_q];
    end else if (cpu_addr == CTRL_ADDR) begin
      kbd_out = status;
    end
  end

endmodule

// File: tb/tb_keyboard_fifo.sv
// Bench for keyboard_fifo: one instance per full-policy, driven in lockstep and
// checked every cycle against a queue-based model plus literal spot checks.
module tb_keyboard_fifo;

  localparam int          WIDTH = 16;
  localparam int          DEPTH = 8;
  localparam logic [15:0] BASE  = 16'h6000;
  localparam logic [15:0] CTRL  = 16'h6001;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] key_code;
  logic        key_valid;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_we;
  logic [15:0] cpu_wdata;

  logic        ready0, ready1, irq0, irq1;
  logic [15:0] out0, out1;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  logic [15:0] mq0[$];
  logic [15:0] mq1[$];
  logic [15:0] wq[$];
  bit          ov0 = 0, ov1 = 0, wov = 0;

  always #5 clk = ~clk;

  keyboard_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE), .DROP_ON_FULL(0)) dut0 (
    .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid), .key_ready(ready0),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .kbd_out(out0), .kbd_irq(irq0));

  keyboard_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE), .DROP_ON_FULL(1)) dut1 (
    .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid), .key_ready(ready1),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .kbd_out(out1), .kbd_irq(irq1));

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One clock of the abstract model on the working copy wq/wov.
  task automatic doStep(input bit drop);
    int  n;
    bit  isFull, rdy, flush, clr, push, pop, ev;
    n      = wq.size();
    isFull = (n == DEPTH);
    rdy    = drop || !isFull;
    flush  = cpu_we && cpu_addr == CTRL && cpu_wdata[0];
    clr    = cpu_we && cpu_addr == CTRL && cpu_wdata[1];
    push   = key_valid && rdy;
    pop    = cpu_rd && cpu_addr == BASE && n > 0;
    ev     = 0;
    if (reset) begin
      wq.delete();
      wov = 0;
    end else begin
      if (flush) begin
        wq.delete();
      end else begin
        if (pop) void'(wq.pop_front());
        if (push) begin
          if (isFull && !pop) ev = 1;
          else wq.push_back(key_code);
        end
      end
      wov = ev | (wov & !clr);
    end
  endtask

  always @(posedge clk) begin
    wq = mq0; wov = ov0; doStep(1'b0); mq0 = wq; ov0 = wov;
    wq = mq1; wov = ov1; doStep(1'b1); mq1 = wq; ov1 = wov;
  end

  function automatic logic [15:0] expOut(input int n, input logic [15:0] head, input bit ov);
    if (cpu_addr == BASE) return (n > 0) ? head : 16'h0000;
    if (cpu_addr == CTRL) return {ov, n == DEPTH, n == 0, 5'b0, 8'(n)};
    return 16'h0000;
  endfunction

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("ready0", {15'b0, ready0}, {15'b0, !reset && mq0.size() < DEPTH});
      checkOutput("ready1", {15'b0, ready1}, {15'b0, !reset});
      checkOutput("irq0", {15'b0, irq0}, {15'b0, mq0.size() > 0});
      checkOutput("irq1", {15'b0, irq1}, {15'b0, mq1.size() > 0});
      checkOutput("out0", out0, expOut(mq0.size(), (mq0.size() > 0) ? mq0[0] : 16'h0, ov0));
      checkOutput("out1", out1, expOut(mq1.size(), (mq1.size() > 0) ? mq1[0] : 16'h0, ov1));
    end
  end

  task automatic applyStimulus(input bit rst, input bit v, input logic [15:0] code,
                               input logic [15:0] addr, input bit rd, input bit we,
                               input logic [15:0] wd);
    reset = rst; key_valid = v; key_code = code;
    cpu_addr = addr; cpu_rd = rd; cpu_we = we; cpu_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 16'h0, 16'h0000, 0, 0, 16'h0);
  endtask

  task automatic push(input logic [15:0] code);
    applyStimulus(0, 1, code, 16'h0000, 0, 0, 16'h0);
  endtask

  task automatic pop();
    applyStimulus(0, 0, 16'h0, BASE, 1, 0, 16'h0);
  endtask

  // Set a read address without a clock edge so outputs can be inspected.
  task automatic peek(input logic [15:0] addr);
    reset = 0; key_valid = 0; cpu_rd = 0; cpu_we = 0; cpu_addr = addr;
    #1;
  endtask

  initial begin
    reset = 1; key_valid = 0; key_code = 0; cpu_addr = 0; cpu_rd = 0; cpu_we = 0; cpu_wdata = 0;
    checkEn = 1;
    applyStimulus(1, 1, 16'h00AA, BASE, 1, 0, 16'h0);
    applyStimulus(1, 0, 16'h0, BASE, 0, 0, 16'h0);
    peek(BASE);
    checkOutput("reset_out", out0, 16'h0000);
    checkOutput("reset_irq", {15'b0, irq0}, 16'h0000);

    push(16'h0041);
    peek(BASE);
    checkOutput("push41_out", out0, 16'h0041);
    checkOutput("push41_irq", {15'b0, irq0}, 16'h0001);
    peek(CTRL);
    checkOutput("push41_status", out0, 16'h0001);
    pop();
    peek(BASE);
    checkOutput("pop41_out", out0, 16'h0000);
    peek(CTRL);
    checkOutput("pop41_status", out0, 16'h2000);

    for (int i = 1; i <= 8; i++) push(16'(i));
    peek(CTRL);
    checkOutput("full_ready0", {15'b0, ready0}, 16'h0000);
    checkOutput("full_status0", out0, 16'h4008);
    push(16'h0099);
    peek(CTRL);
    checkOutput("bp_status0", out0, 16'h4008);
    checkOutput("drop_status1", out1, 16'hC008);
    peek(BASE);
    checkOutput("drop_head1", out1, 16'h0001);
    applyStimulus(0, 0, 16'h0, CTRL, 0, 1, 16'h0002);
    peek(CTRL);
    checkOutput("clear_status1", out1, 16'h4008);
    for (int i = 1; i <= 8; i++) begin
      peek(BASE);
      checkOutput("drain_head0", out0, 16'(i));
      pop();
    end
    peek(CTRL);
    checkOutput("drained_status0", out0, 16'h2000);

    for (int i = 0; i < 8; i++) push(16'h0031 + 16'(i));
    applyStimulus(0, 1, 16'h0039, BASE, 1, 0, 16'h0);
    peek(CTRL);
    checkOutput("fullpp_status0", out0, 16'h0007);
    checkOutput("fullpp_status1", out1, 16'h4008);
    for (int i = 0; i < 9; i++) pop();
    peek(CTRL);
    checkOutput("emptypop_status1", out1, 16'h2000);

    push(16'h0011); push(16'h0012); push(16'h0013);
    applyStimulus(0, 1, 16'h0014, BASE, 1, 0, 16'h0);
    peek(CTRL);
    checkOutput("pp3_status", out0, 16'h0003);
    peek(BASE);
    checkOutput("pp3_head", out0, 16'h0012);
    pop(); pop(); pop();
    applyStimulus(0, 1, 16'h0021, BASE, 1, 0, 16'h0);
    peek(CTRL);
    checkOutput("pp0_status", out0, 16'h0001);
    peek(BASE);
    checkOutput("pp0_head", out0, 16'h0021);
    pop();

    for (int i = 0; i < 5; i++) push(16'h0050 + 16'(i));
    applyStimulus(0, 1, 16'h0077, CTRL, 0, 1, 16'h0001);
    peek(CTRL);
    checkOutput("flush_status", out0, 16'h2000);
    checkOutput("flush_irq", {15'b0, irq0}, 16'h0000);

    for (int i = 0; i < 9; i++) push(16'h0060 + 16'(i));
    for (int i = 0; i < 4; i++) pop();
    peek(CTRL);
    checkOutput("pre_reset_status1", out1, 16'h8004);
    applyStimulus(1, 1, 16'h00EE, BASE, 0, 0, 16'h0);
    checkOutput("in_reset_ready1", {15'b0, ready1}, 16'h0000);
    peek(CTRL);
    checkOutput("post_reset_status1", out1, 16'h2000);
    checkOutput("post_reset_ready1", {15'b0, ready1}, 16'h0001);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
